// File: rtl/uart_send_12bit.sv
// rtl/uart_send_12bit.sv - 12-bit word UART transmitter, two 8N1 frames per word (low byte first)
module uart_send_12bit #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_en,
    input  logic [11:0] send_data_12bit,
    output logic        send_ready,
    output logic        uart_tx,
    output logic        byte_done,
    output logic        word_done
);

    localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam logic [15:0] BPS_LAST = 16'(BPS_CNT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] clk_cnt;
    logic [15:0] clk_cnt_n;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_n;
    logic        byte_sel;
    logic        byte_sel_n;
    logic [11:0] data_q;
    logic [11:0] data_n;
    logic [7:0]  shift_byte;
    logic        tx_n;
    logic        bit_end;

    assign bit_end = (clk_cnt == BPS_LAST);

    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        byte_sel_n = byte_sel;
        data_n     = data_q;
        case (state)
            IDLE: begin
                clk_cnt_n = 16'd0;
                if (send_en) begin
                    state_n    = START;
                    data_n     = send_data_12bit;
                    byte_sel_n = 1'b0;
                    bit_idx_n  = 3'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_n = 16'd0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = 16'd0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n  = 16'd0;
                    byte_sel_n = ~byte_sel;
                    // Low byte chains straight into the high byte's start bit.
                    state_n    = byte_sel ? DONE : START;
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end
            DONE: begin
                clk_cnt_n = 16'd0;
                state_n   = IDLE;
            end
            default: begin
                clk_cnt_n = 16'd0;
                state_n   = IDLE;
            end
        endcase
    end

    // The line value is computed from the next state so it can be registered
    // and still change on the same edge as the state.
    always_comb begin
        shift_byte = byte_sel_n ? {4'b0000, data_n[11:8]} : data_n[7:0];
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_byte[bit_idx_n];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            clk_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
            byte_sel <= 1'b0;
            data_q   <= 12'd0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_sel <= byte_sel_n;
            data_q   <= data_n;
            uart_tx  <= tx_n;
        end
    end

    assign send_ready = (state == IDLE);
    assign byte_done  = (state == STOP) && bit_end;
    assign word_done  = (state == DONE);

endmodule

// File: tb/tb_uart_send_12bit.sv
// tb/tb_uart_send_12bit.sv - scoreboard bench for uart_send_12bit (BPS_CNT = 10)
module tb_uart_send_12bit;

    localparam int BPS      = 10;
    localparam int WORD_CYC = 20 * BPS + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send_en = 1'b0;
    logic [11:0] send_data = 12'd0;
    logic        send_ready;
    logic        uart_tx;
    logic        byte_done;
    logic        word_done;

    uart_send_12bit #(
        .CLK_FREQ (1_000_000),
        .UART_BPS (100_000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .send_en         (send_en),
        .send_data_12bit (send_data),
        .send_ready      (send_ready),
        .uart_tx         (uart_tx),
        .byte_done       (byte_done),
        .word_done       (word_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h expected nothing at cycle %0d", name, act, cyc);
    endtask

    // Scoreboard queues, filled when the bench's own ready model accepts a word.
    logic [7:0] exp_bytes[$];
    int         exp_start[$];
    int         exp_bd[$];
    int         exp_wd[$];
    int         mdl_free_at = 0;
    int         n_acc = 0;
    logic       hand_ok = 1'b0;
    logic [7:0] hand_b0 = 8'd0;
    logic [7:0] hand_b1 = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_bytes.delete();
            exp_start.delete();
            exp_bd.delete();
            exp_wd.delete();
            mdl_free_at = cyc + 1;
        end else begin
            check("send_ready", 32'(send_ready), 32'(cyc >= mdl_free_at));
            if (cyc >= mdl_free_at) check("idle_line", 32'(uart_tx), 32'd1);
            if (send_en && cyc >= mdl_free_at) begin
                if (hand_ok) begin
                    exp_bytes.push_back(hand_b0);
                    exp_bytes.push_back(hand_b1);
                    hand_ok = 1'b0;
                end else begin
                    exp_bytes.push_back(send_data[7:0]);
                    exp_bytes.push_back({4'h0, send_data[11:8]});
                end
                exp_start.push_back(cyc + 1);
                exp_start.push_back(cyc + 1 + 10 * BPS);
                exp_bd.push_back(cyc + 10 * BPS);
                exp_bd.push_back(cyc + 20 * BPS);
                exp_wd.push_back(cyc + 20 * BPS + 1);
                mdl_free_at = cyc + WORD_CYC;
                n_acc++;
            end
        end
    end

    // Line decoder: samples each bit in its middle.
    logic       mon_busy = 1'b0;
    int         mon_cnt = 0;
    int         mon_t0 = 0;
    logic [9:0] mon_bits = 10'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                mon_t0   = cyc;
            end
        end else begin
            mon_cnt++;
            if ((mon_cnt % BPS) == 4) begin
                mon_bits[mon_cnt / BPS] = uart_tx;
                if (mon_cnt / BPS == 9) begin
                    mon_busy = 1'b0;
                    check("start_bit", 32'(mon_bits[0]), 32'd0);
                    check("stop_bit", 32'(mon_bits[9]), 32'd1);
                    if (exp_bytes.size() == 0) begin
                        fail_now("unexpected_byte", 32'(mon_bits[8:1]));
                    end else begin
                        check("byte_value", 32'(mon_bits[8:1]), 32'(exp_bytes.pop_front()));
                        check("start_cycle", 32'(mon_t0), 32'(exp_start.pop_front()));
                    end
                end
            end
        end
    end

    int n_bd = 0;
    int n_wd = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_done === 1'b1) begin
                n_bd++;
                if (exp_bd.size() == 0) fail_now("byte_done_unexpected", 32'(cyc));
                else check("byte_done_cycle", 32'(cyc), 32'(exp_bd.pop_front()));
            end
            if (word_done === 1'b1) begin
                n_wd++;
                if (exp_wd.size() == 0) fail_now("word_done_unexpected", 32'(cyc));
                else check("word_done_cycle", 32'(cyc), 32'(exp_wd.pop_front()));
            end
        end
    end

    task automatic wait_free();
        int g = 0;
        while (cyc < mdl_free_at && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 1000) fail_now("wait_free_timeout", 32'(cyc));
    endtask

    task automatic send_word(input logic [11:0] d, input logic [7:0] b0, input logic [7:0] b1);
        wait_free();
        hand_b0   = b0;
        hand_b1   = b1;
        hand_ok   = 1'b1;
        send_data = d;
        send_en   = 1'b1;
        @(posedge clk);
        #1;
        send_en = 1'b0;
    endtask

    task automatic wait_idle();
        wait_free();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
    endtask

    int bd0;
    int wd0;
    int target;
    int g3;

    initial begin
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx", 32'(uart_tx), 32'd1);
        check("reset_ready", 32'(send_ready), 32'd1);
        check("reset_byte_done", 32'(byte_done), 32'd0);
        check("reset_word_done", 32'(word_done), 32'd0);
        @(posedge clk);
        #1;

        send_word(12'hA5C, 8'h5C, 8'h0A);
        wait_idle();
        send_word(12'hFFF, 8'hFF, 8'h0F);
        send_word(12'h000, 8'h00, 8'h00);
        wait_idle();

        // Held request with data changing every clock: back-to-back words.
        target    = n_acc + 3;
        g3        = 0;
        hand_ok   = 1'b0;
        send_data = 12'($urandom);
        send_en   = 1'b1;
        while (n_acc < target && g3 < 2000) begin
            @(posedge clk);
            #1;
            send_data = 12'($urandom);
            g3++;
        end
        send_en = 1'b0;
        if (g3 >= 2000) fail_now("burst_timeout", 32'(n_acc));
        wait_idle();

        // Request mid-word must be ignored.
        send_word(12'h5A3, 8'hA3, 8'h05);
        repeat (49) begin
            @(posedge clk);
            #1;
        end
        send_data = 12'h123;
        send_en   = 1'b1;
        @(posedge clk);
        #1;
        send_en = 1'b0;
        wait_idle();

        // Reset during the high byte's data bits aborts the word.
        send_word(12'h3C7, 8'hC7, 8'h03);
        repeat (150) begin
            @(posedge clk);
            #1;
        end
        bd0   = n_bd;
        wd0   = n_wd;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_tx", 32'(uart_tx), 32'd1);
        check("abort_ready", 32'(send_ready), 32'd1);
        repeat (250) begin
            @(posedge clk);
            #1;
        end
        check("abort_no_byte_done", 32'(n_bd - bd0), 32'd0);
        check("abort_no_word_done", 32'(n_wd - wd0), 32'd0);
        send_word(12'h81E, 8'h1E, 8'h08);
        wait_idle();

        bd0 = n_bd;
        wd0 = n_wd;
        send_word(12'h001, 8'h01, 8'h00);
        send_word(12'h800, 8'h00, 8'h08);
        send_word(12'h7FE, 8'hFE, 8'h07);
        send_word(12'hC35, 8'h35, 8'h0C);
        wait_idle();
        check("four_words_byte_done", 32'(n_bd - bd0), 32'd8);
        check("four_words_word_done", 32'(n_wd - wd0), 32'd4);

        check("bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("byte_done_left", 32'(exp_bd.size()), 32'd0);
        check("word_done_left", 32'(exp_wd.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got cycle %0d expected end of test", cyc);
        $fatal(1);
    end

endmodule
